// File: rtl/key_entry_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : key_entry_scheduler
//  Purpose  : Sequences decoded PS/2 key events into the digit shift register
//             and the calculation FSM. Key events are buffered in a small FIFO
//             so keystrokes arriving during a calculation are kept. Limits the
//             digit count, issues one start pulse per Enter and supervises
//             completion with a timeout.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock (clk100mhz domain)
//    reset        in   asynchronous active-low reset
//    key_valid    in   one-cycle key strobe from the PS/2 manager
//    key_code     in   [3:0] hex digit value
//    key_flags    in   [1:0] 01 digit, 10 Enter, 11 Clear, 00 ignore
//    calc_done    in   fsm result-ready pulse
//    calc_error   in   fsm error, qualified by calc_done
//    digit_we     out  shift-register write strobe
//    digit_data   out  [3:0] digit carried by digit_we
//    clear_req    out  operand-clear pulse
//    calc_start   out  calculation start pulse
//    busy         out  high while waiting for calc_done
//    digit_count  out  [2:0] digits accepted in the current operand
//    error_flag   out  sticky calculation error
//    timeout      out  pulse on calculation timeout abort
//    key_dropped  out  pulse when an event is lost on a full FIFO
//    overflow     out  pulse when a digit is rejected at MAX_DIGITS
//  Build option
//    KEY_ENTRY_REPEAT_FILTER_EN : suppress repeated identical events that
//                                 arrive within REPEAT_HOLDOFF cycles.
// ============================================================================
module key_entry_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_DIGITS     = 4,
  parameter int DONE_TIMEOUT   = 1000000,
  parameter int REPEAT_HOLDOFF = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [1:0] key_flags,
  input  logic       calc_done,
  input  logic       calc_error,
  output logic       digit_we,
  output logic [3:0] digit_data,
  output logic       clear_req,
  output logic       calc_start,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       error_flag,
  output logic       timeout,
  output logic       key_dropped,
  output logic       overflow
);

  localparam int         c_AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         c_TW         = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(DONE_TIMEOUT - 1);
  localparam logic [c_AW:0]   c_FIFO_FULL  = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0] c_MAX_DIGITS = 3'(MAX_DIGITS);
  localparam logic [1:0] c_FLAG_DIGIT = 2'b01;
  localparam logic [1:0] c_FLAG_ENTER = 2'b10;
  localparam logic [1:0] c_FLAG_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DISPATCH  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_go_wait;
  logic [c_TW-1:0]   r_timer;

  logic [5:0]        r_fifo_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_fifo_cnt;

  logic [5:0]        w_entry;
  logic [5:0]        w_head;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_key_qual;
  logic              w_repeat_block;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_entry      = {key_flags, key_code};
  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_full  = (r_fifo_cnt == c_FIFO_FULL);
  assign w_key_qual   = key_valid && (key_flags != 2'b00);
  assign w_push_req   = w_key_qual && !w_repeat_block;
  assign w_pop        = (r_state == S_IDLE) && !w_fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push       = w_push_req && (!w_fifo_full || w_pop);
  assign w_drop       = w_push_req && w_fifo_full && !w_pop;

`ifdef KEY_ENTRY_REPEAT_FILTER_EN
  localparam int c_HW = $clog2(REPEAT_HOLDOFF + 1);
  localparam logic [c_HW-1:0] c_HOLDOFF = c_HW'(REPEAT_HOLDOFF);

  logic [5:0]      r_last_entry;
  logic            r_last_valid;
  logic [c_HW-1:0] r_holdoff;   // cycles elapsed since the last accepted push

  assign w_repeat_block = r_last_valid && (r_last_entry == w_entry) &&
                          (r_holdoff < c_HOLDOFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_entry <= '0;
      r_last_valid <= 1'b0;
      r_holdoff    <= '0;
    end else if (w_push) begin
      r_last_entry <= w_entry;
      r_last_valid <= 1'b1;
      r_holdoff    <= c_HW'(1);
    end else if (r_holdoff < c_HOLDOFF) begin
      r_holdoff    <= r_holdoff + c_HW'(1);
    end
  end
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = (REPEAT_HOLDOFF > 0);
  assign w_repeat_block   = 1'b0;
`endif

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (c_AW + 1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (c_AW + 1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // The popped entry is decoded on the pop edge so that the registered
  // strobes are already high during the DISPATCH cycle; r_go_wait is the
  // only part of the held entry still needed when DISPATCH completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_go_wait   <= 1'b0;
      r_timer     <= '0;
      digit_we    <= 1'b0;
      digit_data  <= 4'h0;
      clear_req   <= 1'b0;
      calc_start  <= 1'b0;
      busy        <= 1'b0;
      digit_count <= 3'd0;
      error_flag  <= 1'b0;
      timeout     <= 1'b0;
      key_dropped <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      digit_we    <= 1'b0;
      clear_req   <= 1'b0;
      calc_start  <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      key_dropped <= w_drop;

      case (r_state)
        S_IDLE: begin
          if (!w_fifo_empty) begin
            r_state   <= S_DISPATCH;
            r_go_wait <= 1'b0;
            case (w_head[5:4])
              c_FLAG_DIGIT: begin
                if (digit_count < c_MAX_DIGITS) begin
                  digit_we    <= 1'b1;
                  digit_data  <= w_head[3:0];
                  digit_count <= digit_count + 3'd1;
                end else begin
                  overflow    <= 1'b1;
                end
              end
              c_FLAG_ENTER: begin
                if (digit_count != 3'd0) begin
                  calc_start <= 1'b1;
                  r_go_wait  <= 1'b1;
                end
              end
              c_FLAG_CLEAR: begin
                clear_req   <= 1'b1;
                digit_count <= 3'd0;
                error_flag  <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        S_DISPATCH: begin
          r_timer <= '0;
          if (r_go_wait) begin
            r_state <= S_WAIT_DONE;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_WAIT_DONE: begin
          // calc_done takes priority over the timeout boundary.
          if (calc_done) begin
            if (calc_error) error_flag <= 1'b1;
            digit_count <= 3'd0;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_timer == c_TIMER_LAST) begin
            timeout     <= 1'b1;
            digit_count <= 3'd0;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
